// File: rtl/stopwatch_timer_pkg.sv
// Shared types and constants for the mm:ss stopwatch timer.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    bcd_t min_tens;
    bcd_t min_ones;
    bcd_t sec_tens;
    bcd_t sec_ones;
  } digits_t;

  localparam bcd_t SEC_TENS_MAX = 4'd5;
  localparam bcd_t MIN_TENS_MAX = 4'd5;
  localparam bcd_t ONES_MAX     = 4'd9;

  // Count one tick short of saturation; the next tick lands on 59:59.
  localparam digits_t SAT_PRE = '{min_tens: 4'd5, min_ones: 4'd9,
                                  sec_tens: 4'd5, sec_ones: 4'd8};

endpackage

// File: rtl/stopwatch_timer_if.sv
// Control pulses in, BCD digits and status out, between solver logic and digit sprites.
interface stopwatch_timer_if;
  import stopwatch_pkg::*;

  logic start;
  logic stop;
  logic clear;
  logic lap;
  bcd_t min_tens;
  bcd_t min_ones;
  bcd_t sec_tens;
  bcd_t sec_ones;
  logic running;
  logic overflow;
  logic lap_active;

  modport master (
    output start, stop, clear, lap,
    input  min_tens, min_ones, sec_tens, sec_ones, running, overflow, lap_active
  );

  modport slave (
    input  start, stop, clear, lap,
    output min_tens, min_ones, sec_tens, sec_ones, running, overflow, lap_active
  );

endinterface

// File: rtl/stopwatch_timer_bcd.sv
// Single BCD digit counting 0..MAX; carry flags the wrap so digits can be chained.
module bcd_digit_counter
  import stopwatch_pkg::*;
#(
  parameter bcd_t MAX = ONES_MAX
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output bcd_t q,
  output logic carry
);

  assign carry = inc && (q == MAX);

  // Digit register: clear wins over increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= 4'd0;
    end else if (clr) begin
      q <= 4'd0;
    end else if (inc) begin
      q <= (q == MAX) ? 4'd0 : q + 4'd1;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/stopwatch_timer.sv
// Solve-timer core: prescaled mm:ss BCD count driven by start/stop/clear pulses.
// Optional display freeze (lap) is built when STOPWATCH_LAP_EN is defined.
module stopwatch_timer
  import stopwatch_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 25_000_000,
  parameter int TICK_HZ     = 1
) (
  input  logic              clk,
  input  logic              reset,
  stopwatch_timer_if.slave  bus
);

  localparam int DIV = CLK_FREQ_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] DIV_LAST = PW'(DIV - 1);

  state_t        state_r;
  logic [PW-1:0] prescaler_r;
  logic          running_r;
  logic          overflow_r;
  logic          tick_s;
  logic          c_sec_ones_s, c_sec_tens_s, c_min_ones_s, min_tens_carry_unused;
  bcd_t          sec_ones_s, sec_tens_s, min_ones_s, min_tens_s;
  digits_t       live_s;
  digits_t       disp_s;

  // A tick that coincides with stop or clear is dropped, never deferred.
  assign tick_s = (state_r == RUN) && (prescaler_r == DIV_LAST) && !bus.stop && !bus.clear;
  assign live_s = '{min_tens: min_tens_s, min_ones: min_ones_s,
                    sec_tens: sec_tens_s, sec_ones: sec_ones_s};

  bcd_digit_counter #(.MAX(ONES_MAX)) u_sec_ones (
    .clk(clk), .reset(reset), .clr(bus.clear), .inc(tick_s),
    .q(sec_ones_s), .carry(c_sec_ones_s));
  bcd_digit_counter #(.MAX(SEC_TENS_MAX)) u_sec_tens (
    .clk(clk), .reset(reset), .clr(bus.clear), .inc(c_sec_ones_s),
    .q(sec_tens_s), .carry(c_sec_tens_s));
  bcd_digit_counter #(.MAX(ONES_MAX)) u_min_ones (
    .clk(clk), .reset(reset), .clr(bus.clear), .inc(c_sec_tens_s),
    .q(min_ones_s), .carry(c_min_ones_s));
  bcd_digit_counter #(.MAX(MIN_TENS_MAX)) u_min_tens (
    .clk(clk), .reset(reset), .clr(bus.clear), .inc(c_min_ones_s),
    .q(min_tens_s), .carry(min_tens_carry_unused));

  // Control FSM with prescaler, saturation and registered status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      prescaler_r <= '0;
      running_r   <= 1'b0;
      overflow_r  <= 1'b0;
    end else if (bus.clear) begin
      state_r     <= IDLE;
      prescaler_r <= '0;
      running_r   <= 1'b0;
      overflow_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.start && !bus.stop) begin
            state_r     <= RUN;
            running_r   <= 1'b1;
            prescaler_r <= '0;
          end
        end
        RUN: begin
          if (bus.stop) begin
            state_r   <= HOLD;
            running_r <= 1'b0;
          end else if (tick_s) begin
            prescaler_r <= '0;
            if (live_s == SAT_PRE) begin
              overflow_r <= 1'b1;
              state_r    <= HOLD;
              running_r  <= 1'b0;
            end
          end else begin
            prescaler_r <= prescaler_r + PW'(1);
          end
        end
        HOLD: begin
          // Prescaler keeps its held value so a resume continues the partial second.
          if (bus.start && !bus.stop && !overflow_r) begin
            state_r   <= RUN;
            running_r <= 1'b1;
          end
        end
        default: begin
          state_r   <= IDLE;
          running_r <= 1'b0;
        end
      endcase
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic    lap_active_r;
  digits_t shadow_r;

  // Lap toggle: freeze a snapshot on entry, release to the live count on exit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lap_active_r <= 1'b0;
      shadow_r     <= '0;
    end else if (bus.clear) begin
      lap_active_r <= 1'b0;
      shadow_r     <= shadow_r;
    end else if (bus.lap && (state_r != IDLE)) begin
      lap_active_r <= !lap_active_r;
      shadow_r     <= lap_active_r ? shadow_r : live_s;
    end else begin
      lap_active_r <= lap_active_r;
      shadow_r     <= shadow_r;
    end
  end

  assign disp_s         = lap_active_r ? shadow_r : live_s;
  assign bus.lap_active = lap_active_r;
`else
  logic lap_unused;
  assign lap_unused     = bus.lap;
  assign disp_s         = live_s;
  assign bus.lap_active = 1'b0;
`endif

  assign bus.min_tens = disp_s.min_tens;
  assign bus.min_ones = disp_s.min_ones;
  assign bus.sec_tens = disp_s.sec_tens;
  assign bus.sec_ones = disp_s.sec_ones;
  assign bus.running  = running_r;
  assign bus.overflow = overflow_r;

endmodule
